rtc_field_editor: RTL and testbench
===================================

RTC_FIELD_EDITOR -- requirements
Module: rtc_field_editor

Interface
REQ-001 Parameter ADDR_W, default 8: RTC register address width.
REQ-002 Parameter FIELDS, default 3: editable fields per mode; CUR_W = max(1, clog2(FIELDS)).
REQ-003 Parameter REPEAT_DLY, default 25000000: hold cycles before the first auto-repeat step.
REQ-004 Parameter REPEAT_PER, default 5000000: cycles between auto-repeat steps.
REQ-005 Ports, in order:
- clk in 1: the block's single clock.
- reset in 1: reset is asynchronous and active-low.
- camb_crono in 1: chronometer edit request.
- camb_hora in 1: time edit request.
- camb_fecha in 1: date edit request.
- reinicio in 1: force the current field to its minimum.
- push in 4: [0] cursor right, [1] cursor left, [2] increment, [3] decrement.
- bus_req out 1: RTC transaction request.
- bus_we out 1: 1 = write, 0 = read.
- dir_rtc out ADDR_W: RTC register address.
- dato out 8: BCD write data.
- bus_ack in 1: transaction-complete strobe.
- dato_rtc in 8: BCD read data, valid with bus_ack.
- cursor out CUR_W: current field index.
- edit_val out 8: working BCD value.
- editing out 1: high in any edit state.

Function
REQ-006 The FSM SHALL have states IDLE, RD_REQ, EDIT, WR_REQ and EXIT_WR.
REQ-007 Mode SHALL be latched on leaving IDLE; if several camb_* are high, priority is crono > hora > fecha.
REQ-008 IDLE->RD_REQ when any camb_* is high; cursor SHALL be set to 0.
REQ-009 RD_REQ SHALL drive bus_req=1, bus_we=0 and dir_rtc=table address until bus_ack; on bus_ack, edit_val<=dato_rtc, dirty<=0, next state EDIT.
REQ-010 bus_req SHALL stay high until bus_ack; bus_ack outside RD_REQ/WR_REQ/EXIT_WR SHALL be ignored; at most one transaction SHALL be outstanding.
REQ-011 push SHALL be registered once; a step fires on a 0->1 edge of the registered bit, and edit_val changes on the next clock (2 cycles after push rises).
REQ-012 Increment in EDIT: edit_val at field max wraps to field min; otherwise BCD +1 (09->10, 19->20); dirty<=1.
REQ-013 Decrement in EDIT: edit_val at field min wraps to field max; otherwise BCD -1 (10->09); dirty<=1.
REQ-014 Increment and decrement edges in the same cycle SHALL both be ignored.
REQ-015 Cursor right/left SHALL wrap FIELDS-1->0 and 0->FIELDS-1; if dirty, go to WR_REQ first, otherwise go directly to RD_REQ for the new field.
REQ-016 A cursor edge together with an inc/dec edge: the cursor move wins and the value step is dropped; right and left together are both ignored.
REQ-017 reinicio in EDIT SHALL set edit_val to field min and dirty<=1; it has priority over inc/dec in the same cycle.
REQ-018 WR_REQ SHALL drive bus_req=1, bus_we=1 and dato=edit_val; on bus_ack, dirty<=0, the cursor update is applied, then RD_REQ.
REQ-019 When all camb_* are low in EDIT: if dirty, go to EXIT_WR (write as in REQ-018, then IDLE); otherwise go to IDLE.
REQ-020 A camb_* change during RD_REQ/WR_REQ SHALL be acted on only after bus_ack.
REQ-021 Field table, cursor 0..2 (address, min, max):
- hora: hh 8'h23 00-23; mm 8'h22 00-59; ss 8'h21 00-59.
- fecha: dd 8'h24 01-31; mm 8'h25 01-12; yy 8'h26 00-99.
- crono: hh 8'h43 00-23; mm 8'h42 00-59; ss 8'h41 00-59.
REQ-022 A non-BCD value read from dato_rtc SHALL be replaced by field min, with dirty<=1.

Reset
REQ-023 While reset is low: state IDLE, bus_req=0, bus_we=0, dir_rtc=0, dato=0, cursor=0, edit_val=8'h00, editing=0, dirty=0, push register and repeat counter cleared.
REQ-024 Reset mid-transaction SHALL drop bus_req immediately and discard the edit.

Configuration
REQ-025 With RTC_AUTO_REPEAT_EN defined: holding inc or dec continuously for REPEAT_DLY cycles in EDIT SHALL issue one step, then one step every REPEAT_PER cycles until release; release or a cursor move resets the counter.
REQ-026 Without RTC_AUTO_REPEAT_EN: exactly one step per press; no repeat counter is synthesised.

Structure
REQ-027 Package rtc_edit_pkg SHALL hold the mode enum (CRONO, HORA, FECHA), the FSM state enum and the field-table constants (address, min, max).
REQ-028 Sub-module rtc_field_table SHALL map (mode, cursor) combinationally to {addr, min, max}; BCD inc/dec stays in the top.

Verification
REQ-029 camb_hora=1, ack returns 8'h23 -> dir_rtc=8'h23 read, edit_val=8'h23; one inc -> edit_val=8'h00.
REQ-030 fecha mm field reads 8'h01; one dec -> 8'h12; cursor right -> write 8'h12 to 8'h25, then read of 8'h26.
REQ-031 Crono ss=8'h59, reinicio and inc in the same cycle -> edit_val=8'h00, dirty; drop camb_crono -> write 8'h00 to 8'h41, then IDLE.
REQ-032 bus_req held for 10 cycles without ack -> no state change; reset asserted at cycle 5 -> all outputs at reset values the same cycle.
REQ-033 Inc and dec edges together -> no change; with RTC_AUTO_REPEAT_EN, REPEAT_DLY=4 and REPEAT_PER=2, inc held for 9 cycles -> 4 steps (press, +4, +6, +8).
REQ-034 Read returns 8'h3A -> edit_val=field min, dirty=1; camb_crono and camb_fecha both high -> crono table used.

Source files
------------

// File: rtl/rtc_edit_pkg.sv
// Shared types and field-table constants for the RTC field editor.
// Holds the edit-mode and FSM enums plus per-field address/range limits.
package rtc_edit_pkg;

   typedef enum logic [1:0] {CRONO, HORA, FECHA} mode_e;

   typedef enum logic [2:0] {IDLE, RD_REQ, EDIT, WR_REQ, EXIT_WR} state_e;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] vmin;
      logic [7:0] vmax;
   } field_t;

   localparam field_t HORA_HH  = '{addr: 8'h23, vmin: 8'h00, vmax: 8'h23};
   localparam field_t HORA_MM  = '{addr: 8'h22, vmin: 8'h00, vmax: 8'h59};
   localparam field_t HORA_SS  = '{addr: 8'h21, vmin: 8'h00, vmax: 8'h59};
   localparam field_t FECHA_DD = '{addr: 8'h24, vmin: 8'h01, vmax: 8'h31};
   localparam field_t FECHA_MM = '{addr: 8'h25, vmin: 8'h01, vmax: 8'h12};
   localparam field_t FECHA_YY = '{addr: 8'h26, vmin: 8'h00, vmax: 8'h99};
   localparam field_t CRONO_HH = '{addr: 8'h43, vmin: 8'h00, vmax: 8'h23};
   localparam field_t CRONO_MM = '{addr: 8'h42, vmin: 8'h00, vmax: 8'h59};
   localparam field_t CRONO_SS = '{addr: 8'h41, vmin: 8'h00, vmax: 8'h59};

   // Out-of-range indices fall back to the first field of the mode.
   function automatic field_t field_lookup(input mode_e mode, input int unsigned idx);
      field_t f;
      unique case (mode)
         HORA:    f = (idx == 1) ? HORA_MM  : (idx == 2) ? HORA_SS  : HORA_HH;
         FECHA:   f = (idx == 1) ? FECHA_MM : (idx == 2) ? FECHA_YY : FECHA_DD;
         default: f = (idx == 1) ? CRONO_MM : (idx == 2) ? CRONO_SS : CRONO_HH;
      endcase
      return f;
   endfunction

   function automatic logic is_bcd(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/rtc_field_table.sv
// Combinational lookup of RTC register address and BCD limits
// for the field selected by (mode, cursor).
module rtc_field_table
   import rtc_edit_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int CUR_W  = 2
) (
   input  mode_e             mode,
   input  logic [CUR_W-1:0]  cursor,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        fmin,
   output logic [7:0]        fmax
);

   field_t f;

   always_comb begin
      f    = field_lookup(mode, 32'(cursor));
      addr = ADDR_W'(f.addr);
      fmin = f.vmin;
      fmax = f.vmax;
   end

endmodule

// File: rtl/rtc_field_editor.sv
// RTC field editor: reads a BCD field over the RTC bus, edits it with push
// buttons and writes it back. Define RTC_AUTO_REPEAT_EN for held-key repeat.
module rtc_field_editor
   import rtc_edit_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int FIELDS     = 3,
   parameter int REPEAT_DLY = 25000000,
   parameter int REPEAT_PER = 5000000,
   localparam int CUR_W     = (FIELDS > 1) ? $clog2(FIELDS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              camb_crono,
   input  logic              camb_hora,
   input  logic              camb_fecha,
   input  logic              reinicio,
   input  logic [3:0]        push,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] dir_rtc,
   output logic [7:0]        dato,
   input  logic              bus_ack,
   input  logic [7:0]        dato_rtc,
   output logic [CUR_W-1:0]  cursor,
   output logic [7:0]        edit_val,
   output logic              editing
);

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   logic [CUR_W-1:0]  cursor_q, cursor_d, pend_q, pend_d, cur_nxt;
   logic [7:0]        edit_val_q, edit_val_d;
   logic              dirty_q, dirty_d;
   logic [3:0]        push_q, push_d, push_dly_q, push_dly_d, edge_v;
   logic              cur_r, cur_l, cur_mv, inc_step, dec_step, rep_inc, rep_dec;
   logic [ADDR_W-1:0] fld_addr;
   logic [7:0]        fld_min, fld_max;

   rtc_field_table #(.ADDR_W(ADDR_W), .CUR_W(CUR_W)) u_table (
      .mode   (mode_q),
      .cursor (cursor_q),
      .addr   (fld_addr),
      .fmin   (fld_min),
      .fmax   (fld_max)
   );

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
   endfunction

   assign edge_v = push_q & ~push_dly_q;
   assign cur_r  = edge_v[0] & ~edge_v[1];
   assign cur_l  = edge_v[1] & ~edge_v[0];
   assign cur_mv = cur_r | cur_l;

`ifdef RTC_AUTO_REPEAT_EN
   localparam int CNT_W = $clog2(((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER) + 1);
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_ph_q, rep_ph_d;

   // rep_ph_q selects the initial delay (0) or the repeat period (1).
   always_comb begin
      rep_cnt_d = '0;
      rep_ph_d  = 1'b0;
      rep_inc   = 1'b0;
      rep_dec   = 1'b0;
      if (state_q == EDIT && (push_q[2] ^ push_q[3]) && !cur_mv) begin
         if (edge_v[2] | edge_v[3]) begin
            rep_cnt_d = CNT_W'(1);
         end else if (rep_cnt_q == (rep_ph_q ? CNT_W'(REPEAT_PER) : CNT_W'(REPEAT_DLY))) begin
            rep_cnt_d = CNT_W'(1);
            rep_ph_d  = 1'b1;
            rep_inc   = push_q[2];
            rep_dec   = push_q[3];
         end else begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
            rep_ph_d  = rep_ph_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_cnt_q <= '0;
         rep_ph_q  <= 1'b0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         rep_ph_q  <= rep_ph_d;
      end
   end
`else
   logic unused_rep;
   assign rep_inc    = 1'b0;
   assign rep_dec    = 1'b0;
   assign unused_rep = ^{REPEAT_DLY, REPEAT_PER};
`endif

   assign inc_step = (edge_v[2] & ~edge_v[3]) | rep_inc;
   assign dec_step = (edge_v[3] & ~edge_v[2]) | rep_dec;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      cursor_d   = cursor_q;
      pend_d     = pend_q;
      edit_val_d = edit_val_q;
      dirty_d    = dirty_q;
      push_d     = push;
      push_dly_d = push_q;
      cur_nxt    = cursor_q;
      if (cur_r)
         cur_nxt = (cursor_q == CUR_W'(FIELDS - 1)) ? '0 : cursor_q + CUR_W'(1);
      else if (cur_l)
         cur_nxt = (cursor_q == '0) ? CUR_W'(FIELDS - 1) : cursor_q - CUR_W'(1);

      unique case (state_q)
         IDLE: begin
            if (camb_crono | camb_hora | camb_fecha) begin
               mode_d   = camb_crono ? CRONO : (camb_hora ? HORA : FECHA);
               cursor_d = '0;
               state_d  = RD_REQ;
            end
         end
         RD_REQ: begin
            if (bus_ack) begin
               edit_val_d = is_bcd(dato_rtc) ? dato_rtc : fld_min;
               dirty_d    = !is_bcd(dato_rtc);
               state_d    = EDIT;
            end
         end
         EDIT: begin
            if (!(camb_crono | camb_hora | camb_fecha)) begin
               state_d = dirty_q ? EXIT_WR : IDLE;
            end else if (cur_mv) begin
               // A dirty field is flushed first; the move lands on the write ack.
               if (dirty_q) begin
                  pend_d  = cur_nxt;
                  state_d = WR_REQ;
               end else begin
                  cursor_d = cur_nxt;
                  state_d  = RD_REQ;
               end
            end else if (reinicio) begin
               edit_val_d = fld_min;
               dirty_d    = 1'b1;
            end else if (inc_step && !dec_step) begin
               edit_val_d = (edit_val_q >= fld_max) ? fld_min : bcd_inc(edit_val_q);
               dirty_d    = 1'b1;
            end else if (dec_step && !inc_step) begin
               edit_val_d = (edit_val_q <= fld_min) ? fld_max : bcd_dec(edit_val_q);
               dirty_d    = 1'b1;
            end
         end
         WR_REQ: begin
            if (bus_ack) begin
               dirty_d  = 1'b0;
               cursor_d = pend_q;
               state_d  = RD_REQ;
            end
         end
         EXIT_WR: begin
            if (bus_ack) begin
               dirty_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      bus_req  = (state_q == RD_REQ) || (state_q == WR_REQ) || (state_q == EXIT_WR);
      bus_we   = (state_q == WR_REQ) || (state_q == EXIT_WR);
      dir_rtc  = bus_req ? fld_addr : '0;
      dato     = bus_we ? edit_val_q : '0;
      cursor   = cursor_q;
      edit_val = edit_val_q;
      editing  = (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         mode_q     <= CRONO;
         cursor_q   <= '0;
         pend_q     <= '0;
         edit_val_q <= 8'h00;
         dirty_q    <= 1'b0;
         push_q     <= '0;
         push_dly_q <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         cursor_q   <= cursor_d;
         pend_q     <= pend_d;
         edit_val_q <= edit_val_d;
         dirty_q    <= dirty_d;
         push_q     <= push_d;
         push_dly_q <= push_dly_d;
      end
   end

endmodule

// File: tb/tb_rtc_field_editor.sv
// Directed, table-driven bench for rtc_field_editor in its default build.
module tb_rtc_field_editor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       camb_crono, camb_hora, camb_fecha, reinicio, bus_ack;
   logic [3:0] push;
   logic [7:0] dato_rtc;
   logic       bus_req, bus_we, editing;
   logic [7:0] dir_rtc, dato, edit_val;
   logic [1:0] cursor;

   int checks   = 0;
   int failures = 0;

   rtc_field_editor #(.ADDR_W(8), .FIELDS(3)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .camb_crono (camb_crono),
      .camb_hora  (camb_hora),
      .camb_fecha (camb_fecha),
      .reinicio   (reinicio),
      .push       (push),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .dir_rtc    (dir_rtc),
      .dato       (dato),
      .bus_ack    (bus_ack),
      .dato_rtc   (dato_rtc),
      .cursor     (cursor),
      .edit_val   (edit_val),
      .editing    (editing)
   );

   always #5 clk = ~clk;

   // Expected vector packs {bus_req, bus_we, dir_rtc, dato, cursor, edit_val, editing}.
   typedef struct {
      logic [2:0]  camb;
      logic        rein;
      logic [3:0]  push;
      logic        ack;
      logic [7:0]  rdat;
      logic [28:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int c, input int r, input int p, input int a, input int d,
                               input int rq, input int we, input int dir, input int dt,
                               input int cu, input int v, input int ed);
      vec_t t;
      t.camb = 3'(c);
      t.rein = 1'(r);
      t.push = 4'(p);
      t.ack  = 1'(a);
      t.rdat = 8'(d);
      t.exp  = {1'(rq), 1'(we), 8'(dir), 8'(dt), 2'(cu), 8'(v), 1'(ed)};
      return t;
   endfunction

   function automatic logic [28:0] outs();
      return {bus_req, bus_we, dir_rtc, dato, cursor, edit_val, editing};
   endfunction

   task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got req=%b we=%b dir=%h dato=%h cur=%0d val=%h ed=%b, want req=%b we=%b dir=%h dato=%h cur=%0d val=%h ed=%b",
                  name, act[28], act[27], act[26:19], act[18:11], act[10:9], act[8:1], act[0],
                  exp[28], exp[27], exp[26:19], exp[18:11], exp[10:9], exp[8:1], exp[0]);
      end
   endtask

   task automatic drive(input logic [2:0] c, input logic r, input logic [3:0] p,
                        input logic a, input logic [7:0] d);
      {camb_crono, camb_hora, camb_fecha} = c;
      reinicio = r;
      push     = p;
      bus_ack  = a;
      dato_rtc = d;
   endtask

   initial begin
      // hora: read 23, inc wraps to 00, exit writes 00
      vecs.push_back(mk(2,0,0,0,'h00, 1,0,'h23,'h00,0,'h00,1));
      vecs.push_back(mk(2,0,0,1,'h23, 0,0,'h00,'h00,0,'h23,1));
      vecs.push_back(mk(2,0,4,0,'h00, 0,0,'h00,'h00,0,'h23,1));
      vecs.push_back(mk(2,0,4,0,'h00, 0,0,'h00,'h00,0,'h00,1));
      vecs.push_back(mk(2,0,0,0,'h00, 0,0,'h00,'h00,0,'h00,1));
      vecs.push_back(mk(0,0,0,0,'h00, 1,1,'h23,'h00,0,'h00,1));
      vecs.push_back(mk(0,0,0,1,'h00, 0,0,'h00,'h00,0,'h00,0));
      // fecha: right, dec wraps 01->12, dirty move writes then reads yy, non-BCD read
      vecs.push_back(mk(1,0,0,0,'h00, 1,0,'h24,'h00,0,'h00,1));
      vecs.push_back(mk(1,0,0,1,'h15, 0,0,'h00,'h00,0,'h15,1));
      vecs.push_back(mk(1,0,1,0,'h00, 0,0,'h00,'h00,0,'h15,1));
      vecs.push_back(mk(1,0,0,0,'h00, 1,0,'h25,'h00,1,'h15,1));
      vecs.push_back(mk(1,0,0,1,'h01, 0,0,'h00,'h00,1,'h01,1));
      vecs.push_back(mk(1,0,8,0,'h00, 0,0,'h00,'h00,1,'h01,1));
      vecs.push_back(mk(1,0,0,0,'h00, 0,0,'h00,'h00,1,'h12,1));
      vecs.push_back(mk(1,0,1,0,'h00, 0,0,'h00,'h00,1,'h12,1));
      vecs.push_back(mk(1,0,0,0,'h00, 1,1,'h25,'h12,1,'h12,1));
      vecs.push_back(mk(1,0,0,0,'h00, 1,1,'h25,'h12,1,'h12,1));
      vecs.push_back(mk(1,0,0,1,'h00, 1,0,'h26,'h00,2,'h12,1));
      vecs.push_back(mk(1,0,0,1,'h3A, 0,0,'h00,'h00,2,'h00,1));
      vecs.push_back(mk(0,0,0,0,'h00, 1,1,'h26,'h00,2,'h00,1));
      vecs.push_back(mk(0,0,0,1,'h00, 0,0,'h00,'h00,2,'h00,0));
      // crono+fecha: crono wins, left wraps to ss, reinicio beats inc
      vecs.push_back(mk(5,0,0,0,'h00, 1,0,'h43,'h00,0,'h00,1));
      vecs.push_back(mk(5,0,0,1,'h59, 0,0,'h00,'h00,0,'h59,1));
      vecs.push_back(mk(5,0,2,0,'h00, 0,0,'h00,'h00,0,'h59,1));
      vecs.push_back(mk(5,0,0,0,'h00, 1,0,'h41,'h00,2,'h59,1));
      vecs.push_back(mk(5,0,0,1,'h59, 0,0,'h00,'h00,2,'h59,1));
      vecs.push_back(mk(5,0,4,0,'h00, 0,0,'h00,'h00,2,'h59,1));
      vecs.push_back(mk(5,1,4,0,'h00, 0,0,'h00,'h00,2,'h00,1));
      vecs.push_back(mk(5,0,0,0,'h00, 0,0,'h00,'h00,2,'h00,1));
      vecs.push_back(mk(5,0,4,0,'h00, 0,0,'h00,'h00,2,'h00,1));
      vecs.push_back(mk(5,1,4,0,'h00, 0,0,'h00,'h00,2,'h00,1));
      vecs.push_back(mk(1,0,0,0,'h00, 0,0,'h00,'h00,2,'h00,1));
      vecs.push_back(mk(0,0,0,0,'h00, 1,1,'h41,'h00,2,'h00,1));
      vecs.push_back(mk(0,0,0,1,'h00, 0,0,'h00,'h00,2,'h00,0));
      // hora: BCD carry/borrow, inc+dec ignored, cursor beats inc, min wrap
      vecs.push_back(mk(2,0,0,0,'h00, 1,0,'h23,'h00,0,'h00,1));
      vecs.push_back(mk(2,0,0,1,'h19, 0,0,'h00,'h00,0,'h19,1));
      vecs.push_back(mk(2,0,4,1,'h55, 0,0,'h00,'h00,0,'h19,1));
      vecs.push_back(mk(2,0,0,0,'h00, 0,0,'h00,'h00,0,'h20,1));
      vecs.push_back(mk(2,0,8,0,'h00, 0,0,'h00,'h00,0,'h20,1));
      vecs.push_back(mk(2,0,0,0,'h00, 0,0,'h00,'h00,0,'h19,1));
      vecs.push_back(mk(2,0,12,0,'h00, 0,0,'h00,'h00,0,'h19,1));
      vecs.push_back(mk(2,0,0,0,'h00, 0,0,'h00,'h00,0,'h19,1));
      vecs.push_back(mk(2,0,8,0,'h00, 0,0,'h00,'h00,0,'h19,1));
      vecs.push_back(mk(2,0,0,0,'h00, 0,0,'h00,'h00,0,'h18,1));
      vecs.push_back(mk(2,0,5,0,'h00, 0,0,'h00,'h00,0,'h18,1));
      vecs.push_back(mk(2,0,0,0,'h00, 1,1,'h23,'h18,0,'h18,1));
      vecs.push_back(mk(2,0,0,1,'h00, 1,0,'h22,'h00,1,'h18,1));
      vecs.push_back(mk(2,0,0,1,'h00, 0,0,'h00,'h00,1,'h00,1));
      vecs.push_back(mk(2,0,8,0,'h00, 0,0,'h00,'h00,1,'h00,1));
      vecs.push_back(mk(2,0,0,0,'h00, 0,0,'h00,'h00,1,'h59,1));
      vecs.push_back(mk(0,0,0,0,'h00, 1,1,'h22,'h59,1,'h59,1));
      vecs.push_back(mk(0,0,0,1,'h00, 0,0,'h00,'h00,1,'h59,0));
      vecs.push_back(mk(0,0,0,1,'h77, 0,0,'h00,'h00,1,'h59,0));
      // fecha dd: 09 -> 10 -> 09, exit writes 09
      vecs.push_back(mk(1,0,0,0,'h00, 1,0,'h24,'h00,0,'h59,1));
      vecs.push_back(mk(1,0,0,1,'h09, 0,0,'h00,'h00,0,'h09,1));
      vecs.push_back(mk(1,0,4,0,'h00, 0,0,'h00,'h00,0,'h09,1));
      vecs.push_back(mk(1,0,0,0,'h00, 0,0,'h00,'h00,0,'h10,1));
      vecs.push_back(mk(1,0,8,0,'h00, 0,0,'h00,'h00,0,'h10,1));
      vecs.push_back(mk(1,0,0,0,'h00, 0,0,'h00,'h00,0,'h09,1));
      vecs.push_back(mk(0,0,0,0,'h00, 1,1,'h24,'h09,0,'h09,1));
      vecs.push_back(mk(0,0,0,1,'h00, 0,0,'h00,'h00,0,'h09,0));

      rst_n = 1'b0;
      drive(3'b000, 1'b0, 4'h0, 1'b0, 8'h00);
      repeat (3) @(posedge clk);
      #1 check("reset_state", outs(), 29'h0);
      @(negedge clk) rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].camb, vecs[i].rein, vecs[i].push, vecs[i].ack, vecs[i].rdat);
         @(posedge clk);
         #1 check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // Read request held without ack, then async reset mid-transaction.
      @(negedge clk) drive(3'b010, 1'b0, 4'h0, 1'b0, 8'h00);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1 check($sformatf("hold_noack%0d", c), outs(), {1'b1, 1'b0, 8'h23, 8'h00, 2'd0, 8'h09, 1'b1});
      end
      @(negedge clk) rst_n = 1'b0;
      #1 check("async_reset", outs(), 29'h0);
      drive(3'b000, 1'b0, 4'h0, 1'b0, 8'h00);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 check("post_reset_idle", outs(), 29'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
